// File: rtl/stopwatch_msr_pkg.sv
// Shared types and constants for the stopwatch: FSM state encoding and
// the fixed millisecond / second ranges of the time-of-day cascade.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2,
        OVF    = 2'd3
    } sw_state_t;

    localparam int MS_W  = 10;
    localparam int SEC_W = 6;

    localparam logic [MS_W-1:0]  MS_MAX  = 10'd999;
    localparam logic [SEC_W-1:0] SEC_MAX = 6'd59;

endpackage

// File: rtl/stopwatch_msr_if.sv
// Command and status bundle of the stopwatch. The controller side (bench or
// host logic) uses the master modport, the stopwatch itself the slave one.
interface stopwatch_msr_if #(
    parameter int CLK_PER_MS = 5000,
    parameter int MAX_MIN    = 59
);
    import stopwatch_pkg::*;

    localparam int PRESC_W = $clog2(CLK_PER_MS);
    localparam int MIN_W   = $clog2(MAX_MIN + 1);

    // Level-sampled commands
    logic               start;
    logic               stop;
    logic               clear;
    logic               lap;

    // Live time and status
    logic               ms_tick;
    logic [MS_W-1:0]    ms_cnt;
    logic [SEC_W-1:0]   sec_cnt;
    logic [MIN_W-1:0]   min_cnt;
    logic               running;
    logic               overflow;
    logic [PRESC_W-1:0] presc_cnt;

    // Captured lap time
    logic [MS_W-1:0]    lap_ms;
    logic [SEC_W-1:0]   lap_sec;
    logic [MIN_W-1:0]   lap_min;
    logic               lap_valid;

    modport master (
        output start, stop, clear, lap,
        input  ms_tick, ms_cnt, sec_cnt, min_cnt, running, overflow, presc_cnt,
        input  lap_ms, lap_sec, lap_min, lap_valid
    );

    modport slave (
        input  start, stop, clear, lap,
        output ms_tick, ms_cnt, sec_cnt, min_cnt, running, overflow, presc_cnt,
        output lap_ms, lap_sec, lap_min, lap_valid
    );

endinterface

// File: rtl/stopwatch_msr_prescaler.sv
// Millisecond prescaler: counts 0..CLK_PER_MS-1 while enabled, holds its
// value while disabled, and flags the last count of each millisecond.
module ms_prescaler #(
    parameter int CLK_PER_MS = 5000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic                          clr,
    output logic [$clog2(CLK_PER_MS)-1:0] cnt,
    output logic                          tick
);

    localparam int                PRESC_W = $clog2(CLK_PER_MS);
    localparam logic [PRESC_W-1:0] CNT_MAX = PRESC_W'(CLK_PER_MS - 1);

    // Tick is combinational so the cascade sees it in the same cycle it advances on.
    assign tick = en && (cnt == CNT_MAX);

    // Count while enabled; clear wins over counting, disabled freezes the value.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: non-blocking assignments here so every flop samples pre-edge values.
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == CNT_MAX) ? '0 : cnt + PRESC_W'(1);
        end
    end

endmodule

// File: rtl/stopwatch_msr.sv
// Stopwatch with minutes/seconds/milliseconds cascade, start/stop/clear
// control FSM, saturating overflow state and a lap capture register.
module stopwatch_msr #(
    parameter int CLK_PER_MS = 5000,
    parameter int MAX_MIN    = 59
) (
    input  logic            clk,
    input  logic            rst,
    stopwatch_msr_if.slave  sw
);
    import stopwatch_pkg::*;

    localparam int               PRESC_W = $clog2(CLK_PER_MS);
    localparam int               MIN_W   = $clog2(MAX_MIN + 1);
    localparam logic [MIN_W-1:0] MIN_MAX = MIN_W'(MAX_MIN);

    sw_state_t          state;
    logic [MS_W-1:0]    ms_q;
    logic [SEC_W-1:0]   sec_q;
    logic [MIN_W-1:0]   min_q;
    logic [MS_W-1:0]    lap_ms_q;
    logic [SEC_W-1:0]   lap_sec_q;
    logic [MIN_W-1:0]   lap_min_q;
    logic               lap_valid_q;
    logic [PRESC_W-1:0] presc;
    logic               tick;
    logic               at_max;
    logic               lap_accept;

    ms_prescaler #(
        .CLK_PER_MS (CLK_PER_MS)
    ) u_presc (
        .clk  (clk),
        .rst  (rst),
        .en   (state == RUN),
        .clr  (sw.clear),
        .cnt  (presc),
        .tick (tick)
    );

    assign at_max     = (ms_q == MS_MAX) && (sec_q == SEC_MAX) && (min_q == MIN_MAX);
    assign lap_accept = sw.lap && (state != IDLE);

    // Control FSM plus time cascade; clear beats everything, then overflow, then stop/start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            ms_q  <= '0;
            sec_q <= '0;
            min_q <= '0;
        end else if (sw.clear) begin
            state <= IDLE;
            ms_q  <= '0;
            sec_q <= '0;
            min_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (sw.start && !sw.stop) state <= RUN;
                end
                RUN: begin
                    if (tick && at_max) begin
                        // Saturate at the top value; the counters simply hold.
                        state <= OVF;
                    end else begin
                        if (tick) begin
                            if (ms_q == MS_MAX) begin
                                ms_q <= '0;
                                if (sec_q == SEC_MAX) begin
                                    sec_q <= '0;
                                    min_q <= min_q + MIN_W'(1);
                                end else begin
                                    sec_q <= sec_q + 6'd1;
                                end
                            end else begin
                                ms_q <= ms_q + 10'd1;
                            end
                        end
                        if (sw.stop) state <= PAUSED;
                    end
                end
                PAUSED: begin
                    if (sw.start && !sw.stop) state <= RUN;
                end
                OVF: begin
                    // Only clear leaves overflow, handled above.
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Lap capture of the displayed (pre-update) time, with a one-cycle valid pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lap_ms_q    <= '0;
            lap_sec_q   <= '0;
            lap_min_q   <= '0;
            lap_valid_q <= 1'b0;
        end else begin
            lap_valid_q <= lap_accept;
            if (lap_accept) begin
                lap_ms_q  <= ms_q;
                lap_sec_q <= sec_q;
                lap_min_q <= min_q;
            end
        end
    end

    assign sw.ms_tick   = tick;
    assign sw.ms_cnt    = ms_q;
    assign sw.sec_cnt   = sec_q;
    assign sw.min_cnt   = min_q;
    assign sw.running   = (state == RUN);
    assign sw.overflow  = (state == OVF);
    assign sw.presc_cnt = presc;
    assign sw.lap_ms    = lap_ms_q;
    assign sw.lap_sec   = lap_sec_q;
    assign sw.lap_min   = lap_min_q;
    assign sw.lap_valid = lap_valid_q;

endmodule

// File: tb/tb_stopwatch_msr.sv
// Directed bench for stopwatch_msr with CLK_PER_MS=4, MAX_MIN=1.
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_stopwatch_msr;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    stopwatch_msr_if #(.CLK_PER_MS(4), .MAX_MIN(1)) sw ();

    stopwatch_msr #(
        .CLK_PER_MS (4),
        .MAX_MIN    (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .sw  (sw)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Global time bound so the run always ends.
    initial begin
        #(10 * 600000);
        $display("FAIL timeout: simulation exceeded its time bound");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        rst      = 1'b1;
        sw.start = 1'b0;
        sw.stop  = 1'b0;
        sw.clear = 1'b0;
        sw.lap   = 1'b0;

        // Reset state
        cyc(2);
        check("rst_running",  sw.running,   0);
        check("rst_overflow", sw.overflow,  0);
        check("rst_ms",       sw.ms_cnt,    0);
        check("rst_sec",      sw.sec_cnt,   0);
        check("rst_min",      sw.min_cnt,   0);
        check("rst_presc",    sw.presc_cnt, 0);
        check("rst_tick",     sw.ms_tick,   0);
        check("rst_lapvalid", sw.lap_valid, 0);
        check("rst_lapms",    sw.lap_ms,    0);
        rst = 1'b0;
        cyc(1);

        // Start from IDLE: first tick 4 cycles after the start cycle
        sw.start = 1'b1;
        cyc(1);                              // k=0
        sw.start = 1'b0;
        check("start_running", sw.running,   1);
        check("start_presc0",  sw.presc_cnt, 0);
        cyc(2);                              // k=2
        check("tick_early",    sw.ms_tick,   0);
        cyc(1);                              // k=3
        check("tick_first",    sw.ms_tick,   1);
        check("tick_first_ms", sw.ms_cnt,    0);
        cyc(1);                              // k=4
        check("ms_after_tick", sw.ms_cnt,    1);

        // Approach 1 s boundary, lap on the same cycle as the wrapping tick
        cyc(3995);                           // k=3999
        check("pre_wrap_ms",   sw.ms_cnt,    999);
        check("pre_wrap_sec",  sw.sec_cnt,   0);
        check("pre_wrap_tick", sw.ms_tick,   1);
        sw.lap = 1'b1;
        cyc(1);                              // k=4000
        sw.lap = 1'b0;
        check("wrap_ms",       sw.ms_cnt,    0);
        check("wrap_sec",      sw.sec_cnt,   1);
        check("wrap_min",      sw.min_cnt,   0);
        check("wrap_presc",    sw.presc_cnt, 0);
        check("lap_valid_hi",  sw.lap_valid, 1);
        check("lap_ms_999",    sw.lap_ms,    999);
        check("lap_sec_0",     sw.lap_sec,   0);
        cyc(1);                              // k=4001, presc=1
        check("lap_valid_lo",  sw.lap_valid, 0);
        check("lap_ms_held",   sw.lap_ms,    999);

        // Pause at presc=2 for 5 cycles, then resume
        sw.stop = 1'b1;
        cyc(1);
        check("pause_running", sw.running,   0);
        check("pause_presc",   sw.presc_cnt, 2);
        cyc(4);
        sw.stop = 1'b0;
        check("pause_presc_hold", sw.presc_cnt, 2);
        check("pause_ms_hold",    sw.ms_cnt,    0);
        check("pause_sec_hold",   sw.sec_cnt,   1);
        check("pause_tick",       sw.ms_tick,   0);
        sw.start = 1'b1;
        cyc(1);
        sw.start = 1'b0;
        check("resume_running", sw.running,   1);
        check("resume_presc",   sw.presc_cnt, 2);
        check("resume_notick",  sw.ms_tick,   0);
        cyc(1);
        check("resume_tick",    sw.ms_tick,   1);
        cyc(1);
        check("resume_ms",      sw.ms_cnt,    1);

        // clear and start together in RUN: clear wins
        sw.clear = 1'b1;
        sw.start = 1'b1;
        cyc(1);
        sw.clear = 1'b0;
        sw.start = 1'b0;
        check("clr_running", sw.running,   0);
        check("clr_ms",      sw.ms_cnt,    0);
        check("clr_sec",     sw.sec_cnt,   0);
        check("clr_presc",   sw.presc_cnt, 0);
        check("clr_lap_kept", sw.lap_ms,   999);

        // start and stop together in IDLE: stays IDLE; lap in IDLE ignored
        sw.start = 1'b1;
        sw.stop  = 1'b1;
        sw.lap   = 1'b1;
        cyc(1);
        sw.start = 1'b0;
        sw.stop  = 1'b0;
        sw.lap   = 1'b0;
        check("ss_idle_running", sw.running,   0);
        check("idle_lap_valid",  sw.lap_valid, 0);
        cyc(1);
        check("ss_idle_presc",   sw.presc_cnt, 0);

        // Async reset mid-RUN, between edges
        sw.start = 1'b1;
        cyc(1);
        sw.start = 1'b0;
        cyc(10);                             // ms=2, presc=2
        check("prerst_ms", sw.ms_cnt, 2);
        #2;
        rst = 1'b1;
        #1;
        check("arst_running", sw.running,   0);
        check("arst_ms",      sw.ms_cnt,    0);
        check("arst_presc",   sw.presc_cnt, 0);
        check("arst_lapms",   sw.lap_ms,    0);
        #2;
        rst = 1'b0;
        cyc(3);
        check("arst_stay_idle", sw.running,   0);
        check("arst_presc_0",   sw.presc_cnt, 0);

        // Full run to overflow at 1:59.999
        sw.start = 1'b1;
        cyc(1);                              // k=0
        sw.start = 1'b0;
        cyc(479999);                         // k=479999
        check("ovf_pre_tick", sw.ms_tick,  1);
        check("ovf_pre_flag", sw.overflow, 0);
        check("ovf_pre_ms",   sw.ms_cnt,   999);
        check("ovf_pre_sec",  sw.sec_cnt,  59);
        check("ovf_pre_min",  sw.min_cnt,  1);
        cyc(1);
        check("ovf_flag",    sw.overflow, 1);
        check("ovf_running", sw.running,  0);
        check("ovf_ms",      sw.ms_cnt,   999);
        check("ovf_sec",     sw.sec_cnt,  59);
        check("ovf_min",     sw.min_cnt,  1);
        check("ovf_tick",    sw.ms_tick,  0);
        sw.start = 1'b1;
        sw.lap   = 1'b1;
        cyc(1);
        sw.start = 1'b0;
        sw.lap   = 1'b0;
        check("ovf_start_ign", sw.overflow,  1);
        check("ovf_hold_ms",   sw.ms_cnt,    999);
        check("ovf_lap_valid", sw.lap_valid, 1);
        check("ovf_lap_min",   sw.lap_min,   1);
        check("ovf_lap_sec",   sw.lap_sec,   59);
        sw.clear = 1'b1;
        cyc(1);
        sw.clear = 1'b0;
        check("ovfclr_flag",  sw.overflow,  0);
        check("ovfclr_run",   sw.running,   0);
        check("ovfclr_ms",    sw.ms_cnt,    0);
        check("ovfclr_sec",   sw.sec_cnt,   0);
        check("ovfclr_min",   sw.min_cnt,   0);
        check("ovfclr_presc", sw.presc_cnt, 0);
        check("ovfclr_lap",   sw.lap_ms,    999);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/stopwatch_msr.md
STOPWATCH_MSR -- requirements
Module: stopwatch_msr

Interface
REQ-001 Parameter: CLK_PER_MS, 5000, clock cycles per millisecond (>=2).
REQ-002 Parameter: MAX_MIN, 59, highest minute value before overflow (1..1023).
REQ-003 Derived widths: PRESC_W = clog2(CLK_PER_MS); MIN_W = clog2(MAX_MIN+1).
REQ-004 Port clk  in  1  system clock; all state updates on rising edge.
REQ-005 Port rst  in  1  reset, asynchronous, active-high.
REQ-006 Port start  in  1  level-sampled command: begin or resume counting.
REQ-007 Port stop  in  1  level-sampled command: pause counting.
REQ-008 Port clear  in  1  level-sampled command: zero all counters and return to IDLE.
REQ-009 Port lap  in  1  level-sampled command: capture current time into lap registers.
REQ-010 Port ms_tick  out  1  one-cycle pulse on each completed millisecond while RUN.
REQ-011 Port ms_cnt  out  10  milliseconds, 0..999.
REQ-012 Port sec_cnt  out  6  seconds, 0..59.
REQ-013 Port min_cnt  out  MIN_W  minutes, 0..MAX_MIN.
REQ-014 Port lap_ms / lap_sec / lap_min  out  10 / 6 / MIN_W  captured time.
REQ-015 Port lap_valid  out  1  one-cycle pulse the cycle after a capture.
REQ-016 Port running  out  1  high exactly when state is RUN.
REQ-017 Port overflow  out  1  high exactly when state is OVF.
REQ-018 Port presc_cnt  out  PRESC_W  current prescaler value, debug.

Function
REQ-019 FSM states SHALL be IDLE, RUN, PAUSED, OVF; reset state IDLE.
REQ-020 Command priority SHALL be clear > stop > start; lap evaluated independently.
REQ-021 IDLE: start -> RUN; stop ignored.
REQ-022 RUN: stop -> PAUSED; clear -> IDLE; start ignored.
REQ-023 PAUSED: start (without stop) -> RUN; clear -> IDLE; all counters hold.
REQ-024 OVF: only clear exits (-> IDLE); start/stop ignored.
REQ-025 clear in any state SHALL zero presc_cnt, ms_cnt, sec_cnt, min_cnt next cycle; lap registers retained.
REQ-026 Prescaler SHALL count 0..CLK_PER_MS-1 only in RUN, wrap to 0, and freeze (not reset) in PAUSED.
REQ-027 ms_tick SHALL be combinational: state==RUN and presc_cnt==CLK_PER_MS-1.
REQ-028 On ms_tick: ms_cnt +1; 999 wraps to 0 with sec_cnt +1; 59 wraps to 0 with min_cnt +1.
REQ-029 ms_tick at 999 ms, 59 s, MAX_MIN min SHALL enter OVF, counters saturated at max, no wrap.
REQ-030 First ms_tick after start from IDLE SHALL occur CLK_PER_MS cycles after the start cycle.
REQ-031 lap in RUN, PAUSED or OVF SHALL register displayed time (pre-increment value if same-cycle tick); lap in IDLE ignored.
REQ-032 lap_valid SHALL pulse one cycle following each accepted lap; lap held high recaptures every cycle.
REQ-033 lap coinciding with clear SHALL capture pre-clear values.

Reset
REQ-034 rst SHALL force state IDLE; all counters, lap registers zero; lap_valid, running, overflow, ms_tick low.
REQ-035 rst asserted mid-RUN SHALL take effect immediately, independent of clk.

Structure
REQ-036 Package stopwatch_pkg SHALL hold the state enum type and constants MS_MAX=999, SEC_MAX=59.
REQ-037 Prescaler SHALL be sub-module ms_prescaler (params CLK_PER_MS; inputs clk, rst, en, clr; outputs cnt, tick).
REQ-038 Time-of-day cascade, FSM and lap capture SHALL reside in stopwatch_msr.

Verification (bench CLK_PER_MS=4, MAX_MIN=1)
REQ-039 rst then start 1 cycle -> first ms_tick 4 cycles later; after 4000 cycles ms=0, sec=1, min=0.
REQ-040 Run to presc_cnt=2, stop 5 cycles, start -> presc resumes at 2, next tick after 2 cycles, time unchanged during pause.
REQ-041 Run 2*60*1000*4 cycles -> overflow=1, running=0, time 1:59.999 held; start ignored; clear -> all zero, IDLE.
REQ-042 start and stop same cycle in IDLE -> stays IDLE; clear and start same cycle in RUN -> IDLE, counters 0.
REQ-043 lap at ms=999 with tick same cycle -> lap_ms=999, lap_valid pulse next cycle; ms_cnt=0, sec_cnt+1.
REQ-044 Assert rst mid-RUN between clock edges -> all outputs zero before next edge; start required to resume.
